// File: rtl/rom_sel_ctrl.sv
// rom_sel_ctrl: steers the shared serial IS line between up to NROM ROM chips.
// Recovers the 56-bit word timing from the CTC sync strobe, captures each
// broadcast instruction, and changes the active ROM only at the word boundary
// (cnt 55 -> 0), so every 10-bit instruction comes entirely from one chip.
module rom_sel_ctrl #(
  parameter int NROM = 8,
  parameter int RW   = 3
) (
  input  logic            cph2,
  input  logic            nrst,
  input  logic            sync,
  input  logic [NROM-1:0] is_rom,
  output logic            is_o,
  output logic [NROM-1:0] rom_en,
  output logic [RW-1:0]   cur_rom,
  output logic            locked,
  output logic            sel_err
);

  // Word timing landmarks (bit times within the 56-bit word)
  localparam logic [5:0] CNT_SLOT = 6'd45;  // bit time where an aligned sync rises
  localparam logic [5:0] CNT_SYNC = 6'd46;  // counter value loaded on a sync rise
  localparam logic [5:0] CNT_LAST = 6'd55;  // last bit time; ROM switch happens here

  // Opcode patterns, instruction bits [9:0], LSB first on the wire
  localparam logic [6:0] OP_SEL  = 7'b0010000;    // select ROM ir[9:7]
  localparam logic [6:0] OP_DSEL = 7'b0110100;    // delayed select ROM ir[9:7]
  localparam logic [9:0] OP_RTN  = 10'b0000110000;
  localparam logic [1:0] OP_JSB  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b11;

  // Number of ROM slots addressable by a RW-bit ROM number
  localparam int NSLOT = 1 << RW;
  localparam logic [RW:0] NROM_W = NROM[RW:0];

  // Word-lock tracker states
  typedef enum logic {
    LK_HUNT   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_e;

  lock_e           lock_q, lock_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            sync_dly_q, sync_dly_d;
  logic [9:0]      ir_q, ir_d;
  logic [RW-1:0]   cur_q, cur_d;
  logic [RW-1:0]   saved_q, saved_d;
  logic [RW-1:0]   pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic            sel_err_q, sel_err_d;
  logic [NROM-1:0] rom_en_q, rom_en_d;

  logic            sync_rise;
  logic            at_slot;
  logic            word_end;
  logic [RW-1:0]   sel_num;
  logic            sel_bad;
  logic            op_sel, op_dsel, op_rtn, op_jsb, op_br;
  logic [NSLOT-1:0] is_pad;

  // ROM inputs widened to a full RW-bit address space; unpopulated slots read 0
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_pad
    if (gi < NROM) begin : g_rom
      assign is_pad[gi] = is_rom[gi];
    end else begin : g_none
      assign is_pad[gi] = 1'b0;
    end
  end

  // One-hot enable follows the next ROM number so the driver flop switches
  // on the same edge as cur_rom
  for (genvar gi = 0; gi < NROM; gi++) begin : g_onehot
    assign rom_en_d[gi] = (cur_d == RW'(gi));
  end

  assign sync_rise = sync & ~sync_dly_q;
  assign at_slot   = (cnt_q == CNT_SLOT);
  assign word_end  = (cnt_q == CNT_LAST) && (lock_q == LK_LOCKED);

  // Opcode classes are disjoint; RTN shares ir[1:0]==00 with the selects but
  // differs in ir[6:0], so at most one of these is true per word
  assign sel_num = ir_q[9:7];
  assign sel_bad = ({1'b0, sel_num} >= NROM_W);
  assign op_sel  = (ir_q[6:0] == OP_SEL);
  assign op_dsel = (ir_q[6:0] == OP_DSEL);
  assign op_rtn  = (ir_q == OP_RTN);
  assign op_jsb  = (ir_q[1:0] == OP_JSB);
  assign op_br   = (ir_q[1:0] == OP_BR);

  // State register: every flop, asynchronously cleared by nrst
  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      lock_q     <= LK_HUNT;
      cnt_q      <= '0;
      sync_dly_q <= 1'b0;
      ir_q       <= '0;
      cur_q      <= '0;
      saved_q    <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      sel_err_q  <= 1'b0;
      rom_en_q   <= NROM'(1);
    end else begin
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      sync_dly_q <= sync_dly_d;
      ir_q       <= ir_d;
      cur_q      <= cur_d;
      saved_q    <= saved_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      sel_err_q  <= sel_err_d;
      rom_en_q   <= rom_en_d;
    end
  end

  // Next state: bit counter, serial capture, word-boundary decode, lock tracking
  always_comb begin
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    sync_dly_d = sync;
    ir_d       = ir_q;
    cur_d      = cur_q;
    saved_d    = saved_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    sel_err_d  = 1'b0;

    // Bit counter: a sync rise re-anchors it, otherwise it wraps 55 -> 0
    if (sync_rise) begin
      cnt_d = CNT_SYNC;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 6'd1;
    end

    // Instruction window: shift in the muxed IS bit, LSB first
    if (sync) begin
      ir_d = {is_o, ir_q[9:1]};
    end

    // Word boundary: act on the instruction just captured
    if (word_end) begin
      if (op_sel || op_dsel) begin
        if (sel_bad) begin
          // Nonexistent ROM: flag it and leave all selection state alone
          sel_err_d = 1'b1;
        end else if (op_sel) begin
          // Immediate select also cancels any armed delayed select
          cur_d    = sel_num;
          pend_v_d = 1'b0;
        end else begin
          pend_d   = sel_num;
          pend_v_d = 1'b1;
        end
      end else if (op_rtn) begin
        cur_d = saved_q;
      end else if (op_jsb) begin
        // One-deep return stack: a nested JSB overwrites the saved ROM
        saved_d = cur_q;
        if (pend_v_q) begin
          cur_d    = pend_q;
          pend_v_d = 1'b0;
        end
      end else if (op_br) begin
        if (pend_v_q) begin
          cur_d    = pend_q;
          pend_v_d = 1'b0;
        end
      end
    end

    // Lock tracking. Losing lock drops any armed delayed select but keeps
    // the current ROM; this overrides a decode on the same edge.
    if (sync_rise) begin
      if (at_slot || (lock_q == LK_HUNT)) begin
        lock_d = LK_LOCKED;
      end else begin
        lock_d   = LK_HUNT;
        pend_v_d = 1'b0;
      end
    end else if ((lock_q == LK_LOCKED) && at_slot && !sync) begin
      // Expected sync did not arrive
      lock_d   = LK_HUNT;
      pend_v_d = 1'b0;
    end
  end

  // Outputs: IS mux is combinational and silenced until word timing is known
  always_comb begin
    locked = (lock_q == LK_LOCKED);
    is_o   = locked & is_pad[cur_q];
  end

  assign rom_en  = rom_en_q;
  assign cur_rom = cur_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_rom_sel_ctrl.sv
// tb_rom_sel_ctrl: drives whole 56-bit words into an 8-ROM and a 4-ROM
// instance sharing the same ROM bit streams, checks both against a word-level
// reference model every cycle, and pins key points with literal expectations.
module tb_rom_sel_ctrl;

  logic       cph2   = 1'b0;
  logic       nrst   = 1'b0;
  logic       sync   = 1'b0;
  logic [7:0] is_rom = 8'h00;

  logic       is_o8, lock8, err8;
  logic [7:0] rom_en8;
  logic [2:0] cur8;
  logic       is_o4, lock4, err4;
  logic [3:0] rom_en4;
  logic [2:0] cur4;

  logic [9:0] instr [8];

  int n_checks = 0;
  int n_fail   = 0;

  rom_sel_ctrl #(.NROM(8), .RW(3)) dut8 (
    .cph2(cph2), .nrst(nrst), .sync(sync), .is_rom(is_rom),
    .is_o(is_o8), .rom_en(rom_en8), .cur_rom(cur8), .locked(lock8), .sel_err(err8)
  );

  rom_sel_ctrl #(.NROM(4), .RW(3)) dut4 (
    .cph2(cph2), .nrst(nrst), .sync(sync), .is_rom(is_rom[3:0]),
    .is_o(is_o4), .rom_en(rom_en4), .cur_rom(cur4), .locked(lock4), .sel_err(err4)
  );

  initial forever #5 cph2 = ~cph2;

  // Reference model state for one instance
  typedef struct packed {
    logic [5:0] cnt;
    logic       locked;
    logic [2:0] cur;
    logic [2:0] saved;
    logic       pv;
    logic [2:0] pend;
    logic       err;
    logic [9:0] ir;
  } mst_t;

  mst_t m [2];
  logic syncd;

  // One bit time of the reference: word rules are applied to the completed
  // instruction at bit time 55, then the timing/lock rules
  function automatic mst_t step(mst_t s, logic sy, logic rise, logic b, int nrom);
    mst_t n;
    int   num;
    n     = s;
    num   = int'(s.ir[9:7]);
    n.err = 1'b0;
    n.cnt = rise ? 6'd46 : ((s.cnt == 6'd55) ? 6'd0 : 6'(s.cnt + 6'd1));
    if (sy) n.ir = {b, s.ir[9:1]};
    if (s.cnt == 6'd55 && s.locked) begin
      if (s.ir[6:0] == 7'b0010000) begin
        if (num >= nrom) n.err = 1'b1;
        else begin n.cur = 3'(num); n.pv = 1'b0; end
      end else if (s.ir[6:0] == 7'b0110100) begin
        if (num >= nrom) n.err = 1'b1;
        else begin n.pend = 3'(num); n.pv = 1'b1; end
      end else if (s.ir == 10'b0000110000) begin
        n.cur = s.saved;
      end else if (s.ir[1:0] == 2'b01) begin
        n.saved = s.cur;
        if (s.pv) begin n.cur = s.pend; n.pv = 1'b0; end
      end else if (s.ir[1:0] == 2'b11) begin
        if (s.pv) begin n.cur = s.pend; n.pv = 1'b0; end
      end
    end
    if (rise) begin
      if (s.cnt == 6'd45 || !s.locked) n.locked = 1'b1;
      else begin n.locked = 1'b0; n.pv = 1'b0; end
    end else if (s.locked && s.cnt == 6'd45 && !sy) begin
      n.locked = 1'b0;
      n.pv     = 1'b0;
    end
    return n;
  endfunction

  // Reference model update
  always @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      m[0]  <= '0;
      m[1]  <= '0;
      syncd <= 1'b0;
    end else begin
      m[0]  <= step(m[0], sync, sync & ~syncd, m[0].locked & is_rom[m[0].cur], 8);
      m[1]  <= step(m[1], sync, sync & ~syncd, m[1].locked & is_rom[m[1].cur], 4);
      syncd <= sync;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model every cycle, mid-period
  always @(negedge cph2) begin
    chk("is_o8",    32'(is_o8),   32'(m[0].locked & is_rom[m[0].cur]));
    chk("cur8",     32'(cur8),    32'(m[0].cur));
    chk("rom_en8",  32'(rom_en8), 32'd1 << m[0].cur);
    chk("locked8",  32'(lock8),   32'(m[0].locked));
    chk("sel_err8", 32'(err8),    32'(m[0].err));
    chk("is_o4",    32'(is_o4),   32'(m[1].locked & is_rom[m[1].cur]));
    chk("cur4",     32'(cur4),    32'(m[1].cur));
    chk("rom_en4",  32'(rom_en4), 32'd1 << m[1].cur);
    chk("locked4",  32'(lock4),   32'(m[1].locked));
    chk("sel_err4", 32'(err4),    32'(m[1].err));
  end

  // One 56-cycle word; sync high for bit times off..off+9 (off<0: no sync).
  // Inside the window each ROM sends its instr[] bits LSB first, else noise.
  task automatic word(input int off, input string tag);
    logic [7:0] v;
    for (int t = 0; t < 56; t++) begin
      sync = (off >= 0) && (t >= off) && (t < off + 10);
      for (int k = 0; k < 8; k++)
        v[k] = sync ? instr[k][t - off] : 1'($urandom_range(0, 1));
      is_rom = v;
      @(posedge cph2); #2;
    end
    $display("word %-10s off=%0d -> cur8=%0d cur4=%0d locked8=%0b err4=%0b",
             tag, off, cur8, cur4, lock8, err4);
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      sync   = 1'b0;
      is_rom = 8'($urandom_range(0, 255));
      @(posedge cph2); #2;
    end
  endtask

  function automatic logic [9:0] sel(input int n);
    return {3'(n), 7'b0010000};
  endfunction

  function automatic logic [9:0] dsel(input int n);
    return {3'(n), 7'b0110100};
  endfunction

  localparam logic [9:0] NOP = 10'b0000000000;
  localparam logic [9:0] JSB = 10'b0000000001;
  localparam logic [9:0] BR  = 10'b0000000011;
  localparam logic [9:0] RTN = 10'b0000110000;

  initial begin
    for (int k = 0; k < 8; k++) instr[k] = NOP;

    // Reset values
    repeat (3) @(posedge cph2);
    #2;
    chk("rst_rom_en8", 32'(rom_en8), 32'h01);
    chk("rst_rom_en4", 32'(rom_en4), 32'h1);
    chk("rst_is_o8",   32'(is_o8),   32'd0);
    chk("rst_locked8", 32'(lock8),   32'd0);
    chk("rst_cur8",    32'(cur8),    32'd0);

    // Free-running sync, lock acquisition
    nrst = 1'b1;
    word(45, "nop");
    word(45, "nop");
    chk("lock_acq", 32'(lock8), 32'd1);
    chk("lock_rom_en8", 32'(rom_en8), 32'h01);

    // Immediate select 5 (out of range for the 4-ROM instance)
    instr[0] = sel(5);
    word(45, "sel5");
    chk("sel5_cur8",    32'(cur8),    32'd5);
    chk("sel5_rom_en8", 32'(rom_en8), 32'h20);
    chk("sel5_err4",    32'(err4),    32'd1);
    chk("sel5_cur4",    32'(cur4),    32'd0);
    instr[0] = NOP; instr[5] = sel(0);
    word(45, "rom5:sel0");
    chk("back0_cur8", 32'(cur8), 32'd0);
    instr[5] = NOP;

    // Delayed select 3, non-branch word, then branch
    instr[0] = dsel(3);
    word(45, "dsel3");
    chk("dsel3_hold", 32'(cur8), 32'd0);
    instr[0] = NOP;
    word(45, "nop");
    chk("dsel3_nobr", 32'(cur8), 32'd0);
    instr[0] = BR;
    word(45, "br");
    chk("br_cur8",    32'(cur8),    32'd3);
    chk("br_rom_en8", 32'(rom_en8), 32'h08);
    chk("br_cur4",    32'(cur4),    32'd3);
    instr[0] = NOP; instr[3] = sel(0);
    word(45, "rom3:sel0");
    instr[3] = NOP;

    // Delayed select 2, JSB, RTN from ROM 2
    instr[0] = dsel(2);
    word(45, "dsel2");
    instr[0] = JSB;
    word(45, "jsb");
    chk("jsb_cur8", 32'(cur8), 32'd2);
    instr[0] = NOP; instr[2] = RTN;
    word(45, "rom2:rtn");
    chk("rtn_cur8", 32'(cur8), 32'd0);
    chk("rtn_cur4", 32'(cur4), 32'd0);
    instr[2] = NOP;

    // Immediate select cancels an armed delayed select
    instr[0] = dsel(1);
    word(45, "dsel1");
    instr[0] = sel(0);
    word(45, "sel0");
    instr[0] = BR;
    word(45, "br");
    chk("cancel_cur8", 32'(cur8), 32'd0);

    // Out-of-range delayed select leaves the pending one in place
    instr[0] = dsel(2);
    word(45, "dsel2");
    instr[0] = dsel(6);
    word(45, "dsel6");
    chk("dsel6_err4", 32'(err4), 32'd1);
    chk("dsel6_err8", 32'(err8), 32'd0);
    instr[0] = BR;
    word(45, "br");
    chk("keep_cur8",    32'(cur8),    32'd6);
    chk("keep_rom_en8", 32'(rom_en8), 32'h40);
    chk("keep_cur4",    32'(cur4),    32'd2);
    instr[0] = NOP; instr[6] = sel(0); instr[2] = sel(0);
    word(45, "sel0");
    instr[6] = NOP; instr[2] = NOP;

    // Misaligned sync drops lock and pending select, suppresses decode
    instr[0] = dsel(3);
    word(45, "dsel3");
    instr[0] = sel(1);
    word(30, "sel1@30");
    chk("mis_locked8", 32'(lock8), 32'd0);
    chk("mis_cur8",    32'(cur8),  32'd0);
    instr[0] = NOP;
    word(45, "relock");
    chk("relock8", 32'(lock8), 32'd1);
    instr[0] = BR;
    word(45, "br");
    chk("mis_pend_clr", 32'(cur8), 32'd0);
    instr[0] = NOP;

    // Missing sync drops lock; next aligned sync restores it
    word(-1, "nosync");
    chk("nosync_locked8", 32'(lock8), 32'd0);
    word(45, "relock");
    chk("nosync_relock8", 32'(lock8), 32'd1);

    // Asynchronous reset mid-word
    instr[0] = sel(5);
    word(45, "sel5");
    instr[0] = NOP;
    idle(20);
    nrst = 1'b0;
    #1;
    chk("arst_cur8",    32'(cur8),    32'd0);
    chk("arst_locked8", 32'(lock8),   32'd0);
    chk("arst_rom_en8", 32'(rom_en8), 32'h01);
    chk("arst_is_o8",   32'(is_o8),   32'd0);
    @(posedge cph2); #2;
    @(posedge cph2); #2;
    nrst = 1'b1;
    word(45, "nop");
    word(45, "nop");
    chk("post_rst_lock8", 32'(lock8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
